// File: rtl/regfile_mp.sv
// Multi-port register file: fixed-priority writes, same-cycle write-to-read bypass,
// post-reset hardware clear sweep and a req/gnt debug port with registered read data.
module regfile_mp #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int NUM_RD      = 2,
    parameter int NUM_WR      = 2,
    parameter int ZERO_REG_EN = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        we_i,
    input  logic [NUM_WR*ADDR_W-1:0] waddr_i,
    input  logic [NUM_WR*DATA_W-1:0] wdata_i,
    input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
    output logic [NUM_RD*DATA_W-1:0] rdata_o,
    output logic                     busy_o,
    input  logic                     dbg_req_i,
    input  logic                     dbg_we_i,
    input  logic [ADDR_W-1:0]        dbg_addr_i,
    input  logic [DATA_W-1:0]        dbg_wdata_i,
    output logic                     dbg_gnt_o,
    output logic                     dbg_rvalid_o,
    output logic [DATA_W-1:0]        dbg_rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [DATA_W-1:0]   regs [DEPTH];
    logic [NUM_WR-1:0]   wr_commit;
    logic                dbg_wr;
    logic                dbg_rd;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG_EN != 0) && (a == '0);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR)
                clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_cnt == {ADDR_W{1'b1}})
            state_nxt = RUN;
    end

    assign busy_o = (state == CLEAR);

    // A port commits unless a lower-index enabled port targets the same address.
    always_comb begin
        wr_commit = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            wr_commit[k] = we_i[k] & ~busy_o & ~is_zero(waddr_i[k*ADDR_W +: ADDR_W]);
            for (int j = 0; j < k; j++) begin
                if (we_i[j] && waddr_i[j*ADDR_W +: ADDR_W] == waddr_i[k*ADDR_W +: ADDR_W])
                    wr_commit[k] = 1'b0;
            end
        end
    end

    assign dbg_gnt_o = dbg_req_i & ~busy_o & (dbg_we_i ? ~|we_i : 1'b1);
    assign dbg_wr    = dbg_gnt_o & dbg_we_i & ~is_zero(dbg_addr_i);
    assign dbg_rd    = dbg_gnt_o & ~dbg_we_i;

    // Storage is left alone while rst is held; the sweep takes over afterwards.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (busy_o) begin
                regs[clr_cnt] <= '0;
            end else begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wr_commit[k])
                        regs[waddr_i[k*ADDR_W +: ADDR_W]] <= wdata_i[k*DATA_W +: DATA_W];
                end
                if (dbg_wr)
                    regs[dbg_addr_i] <= dbg_wdata_i;
            end
        end
    end

    // Highest-index port applied first so the lowest-index match wins the bypass.
    always_comb begin
        rdata_o = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            if (!busy_o && !is_zero(raddr_i[j*ADDR_W +: ADDR_W])) begin
                rdata_o[j*DATA_W +: DATA_W] = regs[raddr_i[j*ADDR_W +: ADDR_W]];
                for (int k = NUM_WR - 1; k >= 0; k--) begin
                    if (we_i[k] && waddr_i[k*ADDR_W +: ADDR_W] == raddr_i[j*ADDR_W +: ADDR_W])
                        rdata_o[j*DATA_W +: DATA_W] = wdata_i[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_rvalid_o <= 1'b0;
            dbg_rdata_o  <= '0;
        end else begin
            dbg_rvalid_o <= dbg_rd;
            if (dbg_rd)
                dbg_rdata_o <= regs[dbg_addr_i];
        end
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised general-purpose register file; successor to the 2-read/1-write core register file.
- Configurable data width, depth, read-port count and write-port count.
- Fixed-priority multi-write arbitration with per-port write-to-read bypass.
- Hardware sweep-clear of all registers after reset, plus a req/gnt debug port with registered read data. Sits between decode (reads) and writeback/ex (writes), with the debug port fed by the jtag block.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2, number of functional read ports.
- NUM_WR, 2, number of functional write ports; port 0 has the highest priority.
- ZERO_REG_EN, 1, 1 = address 0 is hardwired to zero.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- we_i  in  NUM_WR  per-port write enable.
- waddr_i  in  NUM_WR*ADDR_W  write addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- wdata_i  in  NUM_WR*DATA_W  write data, packed the same way.
- raddr_i  in  NUM_RD*ADDR_W  read addresses.
- rdata_o  out  NUM_RD*DATA_W  read data, combinational.
- busy_o  out  1  clear sweep in progress.
- dbg_req_i  in  1  debug access request.
- dbg_we_i  in  1  1 = debug write, 0 = debug read.
- dbg_addr_i  in  ADDR_W  debug address.
- dbg_wdata_i  in  DATA_W  debug write data.
- dbg_gnt_o  out  1  debug request accepted this cycle (combinational).
- dbg_rvalid_o  out  1  debug read data valid (registered).
- dbg_rdata_o  out  DATA_W  debug read data (registered).

Behaviour:
- Reset (rst=1 at a clk edge):
  - state<=CLEAR, clr_cnt<=0, busy_o=1, dbg_rvalid_o<=0, dbg_rdata_o<=0.
  - Register contents are untouched during rst itself.
- State CLEAR (rst=0):
  - Each edge writes regs[clr_cnt]<=0 and increments clr_cnt.
  - On the edge that writes DEPTH-1, state<=RUN and busy_o drops.
  - busy_o is therefore high for exactly DEPTH cycles after rst deasserts.
  - rst asserted mid-sweep restarts the sweep at clr_cnt=0.
- While busy_o=1:
  - Functional writes are dropped.
  - All rdata_o read 0.
  - dbg_gnt_o=0.
- State RUN, writes:
  - The lowest-index port k with we_i[k]=1 and a legal address writes that address.
  - A higher-index port targeting the same address in the same cycle is dropped.
  - Writes to different addresses all commit on the same edge.
  - With ZERO_REG_EN=1, writes to address 0 are dropped on all ports, including debug.
- State RUN, reads (per read port j, combinational, highest precedence first):
  - (1) addr 0 with ZERO_REG_EN=1 -> 0.
  - (2) the lowest-index write port that is enabled and matches the address -> its wdata (same-cycle bypass).
  - (3) otherwise regs[addr].
  - Debug writes are never bypassed.
- Debug port:
  - dbg_gnt_o = dbg_req_i & ~busy_o & (dbg_we_i ? ~|we_i : 1).
  - Debug writes yield to any functional write activity in the same cycle.
  - The requester holds req, we, addr and wdata stable until gnt.
  - Granted write: regs[dbg_addr_i]<=dbg_wdata_i on that edge.
  - Granted read: on the next edge, dbg_rvalid_o<=1 and dbg_rdata_o<=register value as of that edge (pre-write; no bypass).
  - dbg_rvalid_o is a single-cycle pulse; dbg_rdata_o holds its value until the next granted read.
- Back-to-back debug reads are allowed, one per cycle.
- No X may propagate from uninitialised storage after the sweep completes.

Test Plan:
- Reset sweep: preload regs[7]=0xDEADBEEF, pulse rst for 1 cycle -> busy_o high for 32 cycles (DEPTH=32); during the sweep rdata_o=0 and writes are ignored; afterwards reading 7 returns 0.
- Dual-write conflict: we_i=2'b11, waddr port0=port1=5, wdata 0x11/0x22 -> regs[5]=0x11. Different addresses 5/6 -> both written.
- Bypass: same cycle, port1 writes reg 9=0xA5A5A5A5 and raddr0=9 -> rdata0=0xA5A5A5A5 combinationally. Address 0 write of 0x1234 reads back 0.
- Debug write stall: dbg_req=1, dbg_we=1 while we_i=01 -> gnt=0. Next cycle we_i=0 -> gnt=1 and the register is written.
- Debug read: gnt on a read of reg 3=0x55 -> next cycle dbg_rvalid_o=1 with dbg_rdata_o=0x55, then rvalid=0.
- Reset mid-operation: rst at clr_cnt=10 -> the sweep restarts, and busy_o stays high for 32 more cycles.
